oclib_fifo_arbiter: RTL and testbench

OCLIB_FIFO_ARBITER -- requirements
Module: oclib_fifo_arbiter

---
 rtl/oclib_fifo_arbiter.sv | 125 ++++++++++++
 tb/tb_oclib_fifo_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oclib_fifo_arbiter.sv
// Round-robin packet arbiter feeding a shared FIFO write port.
// A grant is held until end-of-packet or MaxBurst beats, then the search
// pointer moves one past the released requester.
module oclib_fifo_arbiter #(
   parameter int unsigned Inputs   = 4,
   parameter int unsigned Width    = 32,
   parameter int unsigned MaxBurst = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [Inputs*Width-1:0]   inData,
   input  logic [Inputs-1:0]         inValid,
   input  logic [Inputs-1:0]         inLast,
   output logic [Inputs-1:0]         inReady,
   output logic [Width-1:0]          outData,
   output logic                      outValid,
   input  logic                      outReady,
   input  logic                      almostFull,
   output logic [$clog2(Inputs)-1:0] grant,
   output logic                      busy
);

   localparam int unsigned GrantW = $clog2(Inputs);
   localparam int unsigned CountW = $clog2(MaxBurst + 1);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e            r_state,   w_state_next;
   logic [GrantW-1:0] r_grant,   w_grant_next;
   logic [GrantW-1:0] r_pointer, w_pointer_next;
   logic [CountW-1:0] r_beats,   w_beats_next;

   logic [GrantW-1:0] w_search_idx;
   logic [GrantW-1:0] w_cand;
   logic [GrantW-1:0] w_grant_inc;
   logic [CountW-1:0] w_beats_inc;
   int unsigned       w_idx;
   logic              w_found;
   logic              w_busy;
   logic              w_xfer;
   logic              w_release;

   // Find the first valid requester at or after the pointer, wrapping around.
   always_comb begin
      w_found      = 1'b0;
      w_search_idx = '0;
      w_idx        = 0;
      w_cand       = '0;
      for (int unsigned k = 0; k < Inputs; k++) begin
         w_idx  = (32'(r_pointer) + k) % Inputs;
         w_cand = GrantW'(w_idx);
         if (!w_found && inValid[w_cand]) begin
            w_found      = 1'b1;
            w_search_idx = w_cand;
         end
      end
   end

   assign w_busy      = (r_state == StBusy);
   assign w_xfer      = w_busy && outValid && outReady;
   assign w_beats_inc = r_beats + CountW'(1);
   assign w_grant_inc = (r_grant == GrantW'(Inputs - 1)) ? '0 : r_grant + GrantW'(1);
   // Release on the beat that ends the packet or exhausts the burst budget.
   assign w_release   = w_xfer && (inLast[r_grant] || (w_beats_inc == CountW'(MaxBurst)));

   // Next-state: grant in idle (gated by almostFull), count and release in busy.
   always_comb begin
      w_state_next   = r_state;
      w_grant_next   = r_grant;
      w_pointer_next = r_pointer;
      w_beats_next   = r_beats;
      unique case (r_state)
         StIdle: begin
            if (w_found && !almostFull) begin
               w_grant_next = w_search_idx;
               w_beats_next = '0;
               w_state_next = StBusy;
            end
         end
         StBusy: begin
            if (w_xfer) begin
               w_beats_next = w_beats_inc;
            end
            if (w_release) begin
               w_state_next   = StIdle;
               w_pointer_next = w_grant_inc;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Outputs: the granted stream is passed straight through while busy.
   always_comb begin
      busy     = w_busy;
      grant    = r_grant;
      outValid = w_busy && inValid[r_grant];
      inReady  = '0;
      outData  = '0;
      if (w_busy) begin
         inReady[r_grant] = outReady;
         for (int unsigned i = 0; i < Inputs; i++) begin
            if (r_grant == GrantW'(i)) begin
               outData = inData[i*Width +: Width];
            end
         end
      end
   end

   // State registers; reset abandons any packet in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= StIdle;
         r_grant   <= '0;
         r_pointer <= '0;
         r_beats   <= '0;
      end else begin
         r_state   <= w_state_next;
         r_grant   <= w_grant_next;
         r_pointer <= w_pointer_next;
         r_beats   <= w_beats_next;
      end
   end

endmodule

// File: tb/tb_oclib_fifo_arbiter.sv
// Bench for oclib_fifo_arbiter: packet sources per requester, a scoreboard of
// expected beats in arbitration order, and a table of one-shot grant vectors.
module tb_oclib_fifo_arbiter;

   localparam int unsigned N = 4;
   localparam int unsigned W = 32;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [N*W-1:0] inData;
   logic [N-1:0]   inValid;
   logic [N-1:0]   inLast;
   logic [N-1:0]   inReady;
   logic [W-1:0]   outData;
   logic           outValid;
   logic           outReady;
   logic           almostFull;
   logic [1:0]     grant;
   logic           busy;

   always #5 clock = ~clock;

   oclib_fifo_arbiter #(
      .Inputs   (N),
      .Width    (W),
      .MaxBurst (16)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .inData     (inData),
      .inValid    (inValid),
      .inLast     (inLast),
      .inReady    (inReady),
      .outData    (outData),
      .outValid   (outValid),
      .outReady   (outReady),
      .almostFull (almostFull),
      .grant      (grant),
      .busy       (busy)
   );

   typedef struct {
      int         req;
      logic [W-1:0] data;
   } exp_t;

   typedef struct {
      int       pre;       // requester served with a 1-beat packet first, -1 = none
      logic [3:0] valid;
      logic     af;
      logic     exp_busy;
      logic [1:0] exp_grant;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[11];
   int   src_len[N];
   int   src_beat[N];
   int   src_pkt[N];
   int   src_left[N];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [W-1:0] beat_data(input int r, input int p, input int b);
      return {8'(r), 8'(p), 16'(b)};
   endfunction

   task automatic drive_src();
      for (int i = 0; i < N; i++) begin
         inValid[i]       = src_left[i] > 0;
         inLast[i]        = src_beat[i] == src_len[i] - 1;
         inData[i*W +: W] = beat_data(i, src_pkt[i], src_beat[i]);
      end
   endtask

   task automatic src_clear();
      for (int i = 0; i < N; i++) begin
         src_len[i]  = 1;
         src_beat[i] = 0;
         src_pkt[i]  = 0;
         src_left[i] = 0;
      end
   endtask

   task automatic src_cfg(input int r, input int len, input int pkts);
      src_len[r]  = len;
      src_beat[r] = 0;
      src_left[r] = pkts;
   endtask

   task automatic push_pkt(input int r, input int p, input int first, input int n);
      for (int b = 0; b < n; b++) sb.push_back('{req: r, data: beat_data(r, p, first + b)});
   endtask

   // One clock: check at negedge, advance sources just after posedge.
   task automatic cycle();
      logic [N-1:0] hs;
      exp_t         e;
      @(negedge clock);
      hs = inValid & inReady;
      if (busy) begin
         if (sb.size() > 0) begin
            chk("grant", 32'(grant), 32'(sb[0].req));
            chk("in_ready", 32'(inReady), outReady ? (32'(1) << sb[0].req) : 32'(0));
         end
         if (outValid && outReady) begin
            n_checks++;
            if (sb.size() == 0) begin
               $display("FAIL unexpected_beat: got data %h, expected no transfer", outData);
            end else begin
               n_checks--;
               e = sb.pop_front();
               chk("out_data", outData, e.data);
            end
         end
      end else begin
         chk("idle_out_valid", 32'(outValid), 32'(0));
         chk("idle_in_ready", 32'(inReady), 32'(0));
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            src_beat[i]++;
            if (src_beat[i] == src_len[i]) begin
               src_beat[i] = 0;
               src_pkt[i]++;
               src_left[i]--;
            end
         end
      end
      drive_src();
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      almostFull = 1'b0;
      outReady   = 1'b1;
      src_clear();
      drive_src();
      sb.delete();
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{-1, 4'b0000, 1'b0, 1'b0, 2'd0};
      vecs[1]  = '{-1, 4'b0001, 1'b0, 1'b1, 2'd0};
      vecs[2]  = '{-1, 4'b1000, 1'b0, 1'b1, 2'd3};
      vecs[3]  = '{-1, 4'b0110, 1'b0, 1'b1, 2'd1};
      vecs[4]  = '{ 0, 4'b0001, 1'b0, 1'b1, 2'd0};
      vecs[5]  = '{ 1, 4'b0011, 1'b0, 1'b1, 2'd0};
      vecs[6]  = '{ 1, 4'b1011, 1'b0, 1'b1, 2'd3};
      vecs[7]  = '{ 3, 4'b1001, 1'b0, 1'b1, 2'd0};
      vecs[8]  = '{ 2, 4'b0110, 1'b0, 1'b1, 2'd1};
      vecs[9]  = '{-1, 4'b1111, 1'b1, 1'b0, 2'd0};
      vecs[10] = '{ 2, 4'b0010, 1'b1, 1'b0, 2'd2};

      // Reset state.
      almostFull = 1'b0;
      outReady   = 1'b1;
      src_clear();
      src_cfg(1, 2, 1);
      drive_src();
      #2;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_grant", 32'(grant), 32'(0));
      chk("rst_out_valid", 32'(outValid), 32'(0));
      chk("rst_in_ready", 32'(inReady), 32'(0));
      chk("rst_out_data", outData, 32'(0));

      // Grant vectors: optional prior packet to move the pointer, then one arbitration.
      for (int v = 0; v < 11; v++) begin
         do_reset();
         if (vecs[v].pre >= 0) begin
            src_cfg(vecs[v].pre, 1, 1);
            push_pkt(vecs[v].pre, 0, 0, 1);
            drive_src();
            cycle();
            cycle();
         end
         for (int i = 0; i < N; i++) if (vecs[v].valid[i]) src_cfg(i, 1, 1);
         almostFull = vecs[v].af;
         drive_src();
         cycle();
         chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
         chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
         chk($sformatf("vec%0d_out_valid", v), 32'(outValid), 32'(vecs[v].exp_busy));
      end

      // Two requesters, 3-beat packets: 0,2,0,2 at 4 cycles each.
      do_reset();
      src_cfg(0, 3, 2);
      src_cfg(2, 3, 2);
      drive_src();
      push_pkt(0, 0, 0, 3);
      push_pkt(2, 0, 0, 3);
      push_pkt(0, 1, 0, 3);
      push_pkt(2, 1, 0, 3);
      repeat (16) cycle();
      chk("alt_sb_empty", 32'(sb.size()), 32'(0));
      chk("alt_busy_end", 32'(busy), 32'(0));

      // Long packets cut at 16 beats, order 0,1,2,3,0.
      do_reset();
      for (int i = 0; i < N; i++) src_cfg(i, 40, 1);
      drive_src();
      for (int i = 0; i < N; i++) push_pkt(i, 0, 0, 16);
      push_pkt(0, 0, 16, 16);
      repeat (85) cycle();
      chk("burst_sb_empty", 32'(sb.size()), 32'(0));
      chk("burst_busy_end", 32'(busy), 32'(0));

      // almostFull holds off a grant while idle.
      do_reset();
      almostFull = 1'b1;
      src_cfg(1, 2, 1);
      drive_src();
      push_pkt(1, 0, 0, 2);
      repeat (3) begin
         cycle();
         chk("af_hold_busy", 32'(busy), 32'(0));
         chk("af_hold_out_valid", 32'(outValid), 32'(0));
      end
      almostFull = 1'b0;
      cycle();
      chk("af_release_busy", 32'(busy), 32'(1));
      chk("af_release_grant", 32'(grant), 32'(1));
      repeat (2) cycle();
      chk("af_sb_empty", 32'(sb.size()), 32'(0));
      chk("af_busy_end", 32'(busy), 32'(0));

      // almostFull rising mid-packet does not cut it short.
      do_reset();
      src_cfg(0, 5, 1);
      src_cfg(1, 1, 1);
      drive_src();
      push_pkt(0, 0, 0, 5);
      repeat (3) cycle();
      almostFull = 1'b1;
      repeat (3) cycle();
      chk("afmid_sb_empty", 32'(sb.size()), 32'(0));
      repeat (3) begin
         cycle();
         chk("afmid_no_grant", 32'(busy), 32'(0));
      end

      // outReady toggling: 4 transfers over 8 cycles, inReady mirrors outReady.
      do_reset();
      src_cfg(3, 4, 1);
      drive_src();
      push_pkt(3, 0, 0, 4);
      cycle();
      for (int k = 0; k < 8; k++) begin
         outReady = (k % 2) == 0;
         cycle();
      end
      chk("toggle_sb_empty", 32'(sb.size()), 32'(0));
      chk("toggle_busy_end", 32'(busy), 32'(0));

      // Reset in the middle of requester 1's packet; pointer returns to 0.
      do_reset();
      src_cfg(0, 1, 1);
      src_cfg(1, 5, 1);
      drive_src();
      push_pkt(0, 0, 0, 1);
      push_pkt(1, 0, 0, 5);
      repeat (5) cycle();
      reset = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'(0));
      chk("midrst_grant", 32'(grant), 32'(0));
      chk("midrst_out_valid", 32'(outValid), 32'(0));
      chk("midrst_in_ready", 32'(inReady), 32'(0));
      sb.delete();
      src_clear();
      src_cfg(0, 2, 1);
      src_cfg(1, 2, 1);
      drive_src();
      push_pkt(0, 0, 0, 2);
      push_pkt(1, 0, 0, 2);
      @(posedge clock);
      #1;
      reset = 1'b0;
      cycle();
      chk("postrst_busy", 32'(busy), 32'(1));
      chk("postrst_grant", 32'(grant), 32'(0));
      repeat (5) cycle();
      chk("postrst_sb_empty", 32'(sb.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
